// File: rtl/frame_config_ctrl_if.sv
// frame_config_ctrl_if: valid/ready word stream from the bitstream source into frame_config_ctrl
//   s_valid/s_data driven by the source (master), s_ready returned by the sequencer (slave)
interface frame_config_ctrl_if #(parameter int W = 32) ();
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    modport master (output s_valid, s_data, input s_ready);
    modport slave  (input s_valid, s_data, output s_ready);
endinterface

// File: rtl/frame_config_ctrl.sv
// frame_config_ctrl: assembles one configuration frame from a word stream and strobes it into a fabric column/frame
//   UserCLK, Reset       : clock, asynchronous active-high reset
//   in_if                : header word (A5 sync, column, frame) then NumRows frame words
//   abort, err_clr       : drop the current frame / clear the sticky header error
//   FrameData            : assembled frame, row k at [k*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe          : single-cycle one-hot write strobe at col*MaxFramesPerCol+frame
//   busy, err, frames_done : status
module frame_config_ctrl #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 8,
    parameter int NumColumns      = 8,
    parameter int SetupCycles     = 1,
    parameter int HoldCycles      = 1
) (
    input  logic                                  UserCLK,
    input  logic                                  Reset,
    frame_config_ctrl_if.slave                    in_if,
    input  logic                                  abort,
    input  logic                                  err_clr,
    output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  err,
    output logic [15:0]                           frames_done
);
    localparam int SW = NumColumns * MaxFramesPerCol;
    localparam int MX = NumRows > SetupCycles ? (NumRows > HoldCycles ? NumRows : HoldCycles)
                                              : (SetupCycles > HoldCycles ? SetupCycles : HoldCycles);
    localparam int CW = $clog2(MX + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    col, frm;
    logic          acc, hdr_ok, last_row;
    logic [SW-1:0] one_hot;

    // s_ready is held low while Reset is asserted, not just after the first edge
    assign in_if.s_ready = !Reset && (state == IDLE || state == LOAD);
    assign acc           = in_if.s_valid && in_if.s_ready;
    assign hdr_ok        = in_if.s_data[31:24] == 8'hA5 && in_if.s_data[23:16] < 8'(NumColumns)
                           && in_if.s_data[15:8] < 8'(MaxFramesPerCol);
    assign last_row      = cnt == CW'(NumRows - 1);
    assign one_hot       = SW'(1) << (int'(col) * MaxFramesPerCol + int'(frm));
    assign busy          = state != IDLE;

    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // cnt counts rows in LOAD and elapsed cycles in SETUP/HOLD
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                state_n = acc && hdr_ok ? LOAD : IDLE;
                cnt_n   = '0;
            end
            LOAD: begin
                if (abort) state_n = IDLE;
                else if (acc) begin
                    state_n = last_row ? SETUP : LOAD;
                    cnt_n   = last_row ? '0 : cnt + 1'b1;
                end
            end
            SETUP: begin
                state_n = abort ? IDLE : (cnt == CW'(SetupCycles - 1) ? STROBE : SETUP);
                cnt_n   = cnt + 1'b1;
            end
            STROBE: begin
                state_n = abort ? IDLE : HOLD;
                cnt_n   = '0;
            end
            HOLD: begin
                state_n = abort || cnt == CW'(HoldCycles - 1) ? IDLE : HOLD;
                cnt_n   = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            FrameData   <= '0;
            FrameStrobe <= '0;
            err         <= 1'b0;
            frames_done <= '0;
            col         <= '0;
            frm         <= '0;
        end else begin
            if (state == IDLE && acc && hdr_ok) begin
                col <= in_if.s_data[23:16];
                frm <= in_if.s_data[15:8];
            end
            if (state == LOAD && acc)
                FrameData[int'(cnt) * FrameBitsPerRow +: FrameBitsPerRow] <= in_if.s_data;
            // a bad header in the same cycle as err_clr leaves err set
            err         <= (state == IDLE && acc && !hdr_ok) || (err && !err_clr);
            // registered so the strobe is glitch-free and only ever high in STROBE
            FrameStrobe <= state_n == STROBE ? one_hot : '0;
            if (state == STROBE)
                frames_done <= frames_done + 16'd1;
        end
    end
endmodule

// File: tb/tb_frame_config_ctrl.sv
// tb_frame_config_ctrl: randomized and directed bench with a timeline reference model of the frame sequencer
module tb_frame_config_ctrl;
    localparam int NR = 8, FB = 32, NC = 8, MF = 20, SU = 1, HO = 1;

    logic              clk = 0, rst = 1, abort = 0, err_clr = 0;
    logic [NR*FB-1:0]  frame_data;
    logic [NC*MF-1:0]  frame_strobe;
    logic              busy, err;
    logic [15:0]       frames_done;
    int                errors = 0, checks = 0;

    frame_config_ctrl_if #(.W(FB)) bus ();

    frame_config_ctrl #(
        .MaxFramesPerCol(MF), .FrameBitsPerRow(FB), .NumRows(NR),
        .NumColumns(NC), .SetupCycles(SU), .HoldCycles(HO)
    ) dut (
        .UserCLK(clk), .Reset(rst), .in_if(bus), .abort(abort), .err_clr(err_clr),
        .FrameData(frame_data), .FrameStrobe(frame_strobe), .busy(busy), .err(err),
        .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a timeline. Once the last word is taken at cycle L the
    // strobe lands at L+SU+1 and the block is free again at strobe+HO+1; abort truncates it.
    int          cyc = 0, strobe_at = -1, free_at = 0, row = 0, acc_cyc = 0;
    bit          loading = 0, m_err = 0;
    logic [15:0] m_done = 0;
    logic [7:0]  m_col = 0, m_frm = 0;
    logic [FB-1:0] m_rows [NR];
    int          strobe_seen = -1;
    logic [NC*MF-1:0] strobe_vec_seen = '0;
    logic [FB-1:0] wd [NR];
    logic [FB-1:0] nw [NR];

    function automatic bit m_idle();
        return !loading && cyc >= free_at;
    endfunction

    function automatic bit m_ready();
        return !rst && (loading || cyc >= free_at);
    endfunction

    function automatic logic [NC*MF-1:0] onehot(input int i);
        logic [NC*MF-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, want);
        end
    endtask

    always @(posedge clk) begin
        bit idle, acc, good;
        logic [NR*FB-1:0] efd;
        logic [NC*MF-1:0] efs;
        if (rst) begin
            loading = 0; strobe_at = -1; free_at = 0; row = 0;
            m_err = 0; m_done = 0; m_col = 0; m_frm = 0;
            for (int k = 0; k < NR; k++) m_rows[k] = '0;
        end else begin
            idle = m_idle();
            acc  = bus.s_valid && m_ready();
            good = bus.s_data[31:24] == 8'hA5 && int'(bus.s_data[23:16]) < NC && int'(bus.s_data[15:8]) < MF;
            if (idle) begin
                if (acc && good) begin
                    loading = 1; row = 0;
                    m_col = bus.s_data[23:16]; m_frm = bus.s_data[15:8];
                end
            end else if (loading) begin
                if (acc) begin m_rows[row] = bus.s_data; row++; end
                if (abort) begin
                    loading = 0; free_at = cyc + 1;
                end else if (acc && row == NR) begin
                    loading = 0; strobe_at = cyc + SU + 1; free_at = strobe_at + HO + 1;
                end
            end else begin
                if (cyc == strobe_at) m_done = m_done + 16'd1;
                if (abort) begin
                    if (cyc < strobe_at) strobe_at = -1;
                    free_at = cyc + 1;
                end
            end
            m_err = (idle && acc && !good) || (m_err && !err_clr);
        end
        cyc++;
        #1;
        for (int k = 0; k < NR; k++) efd[k*FB +: FB] = m_rows[k];
        efs = (cyc == strobe_at && !rst) ? onehot(int'(m_col) * MF + int'(m_frm)) : '0;
        chk("s_ready", bus.s_ready, m_ready());
        chk("busy", busy, !m_idle());
        chk("err", err, m_err);
        chk("frames_done", frames_done, m_done);
        chk("FrameStrobe", frame_strobe, efs);
        chk("FrameData", frame_data, efd);
        if (frame_strobe != '0) begin strobe_seen = cyc; strobe_vec_seen = frame_strobe; end
    end

    task automatic send(input logic [31:0] d, input int gap);
        bit ok;
        ok = 0;
        repeat (gap) @(negedge clk);
        bus.s_valid = 1; bus.s_data = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = m_ready();
            if (ok) acc_cyc = cyc;
            @(negedge clk);
        end
        bus.s_valid = 0;
        chk("send_accepted", ok, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && !m_idle(); i++) @(negedge clk);
        chk("idle_reached", m_idle(), 1'b1);
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] f, input int maxgap);
        send({8'hA5, c, f, 8'h00}, 0);
        for (int k = 0; k < NR; k++) send(wd[k], k < 3 ? 0 : $urandom_range(0, maxgap));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int h, s;
        bus.s_valid = 0; bus.s_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_data, 0);
        chk("rst_fs", frame_strobe, 0);
        chk("rst_done", frames_done, 0);
        rst = 0;
        @(negedge clk);
        chk("ready_after_rst", bus.s_ready, 1);

        // basic frame, zero stalls
        for (int k = 0; k < NR; k++) wd[k] = 32'h1000_0000 + k;
        h = cyc;
        frame(8'd2, 8'd5, 0);
        for (int j = 9; j <= 12; j++) begin
            chk("t1_ready_seq", bus.s_ready, j == 12);
            if (j < 12) @(negedge clk);
        end
        chk("t1_strobe_cycle", strobe_seen - h, 10);
        chk("t1_strobe_vec", strobe_vec_seen, onehot(45));
        chk("t1_done", frames_done, 16'd1);
        for (int k = 0; k < NR; k++) chk("t1_row", frame_data[k*FB +: FB], 32'h1000_0000 + k);

        // bad headers, err_clr, set-wins, err does not block
        send(32'hA508_0000, 0);
        send(32'h5A00_0000, 0);
        send(32'hA500_1400, 0);
        chk("t2_err", err, 1);
        chk("t2_busy", busy, 0);
        chk("t2_done", frames_done, 16'd1);
        err_clr = 1; @(negedge clk); err_clr = 0;
        chk("t2_err_clr", err, 0);
        err_clr = 1; send(32'hFF00_0000, 0); err_clr = 0;
        chk("t2_set_wins", err, 1);
        for (int k = 0; k < NR; k++) wd[k] = $urandom;
        frame(8'd7, 8'd19, 2);
        wait_idle();
        chk("t2_max_index", strobe_vec_seen, onehot(159));
        chk("t2_err_kept", err, 1);
        err_clr = 1; @(negedge clk); err_clr = 0;
        frame(8'd0, 8'd0, 1);
        wait_idle();
        chk("t2_min_index", strobe_vec_seen, onehot(0));
        chk("t2_done3", frames_done, 16'd3);

        // random stalls after the third word
        for (int k = 0; k < NR; k++) wd[k] = $urandom;
        frame(8'd3, 8'd7, 5);
        wait_idle();
        chk("t3_latency", strobe_seen - acc_cyc, SU + 1);
        chk("t3_done", frames_done, 16'd4);

        // abort in LOAD after four words
        s = strobe_seen;
        send(32'hA501_0200, 0);
        for (int k = 0; k < 4; k++) begin nw[k] = $urandom; send(nw[k], 0); end
        abort = 1; @(negedge clk); abort = 0;
        chk("t4_busy", busy, 0);
        chk("t4_done", frames_done, 16'd4);
        chk("t4_no_strobe", strobe_seen, s);
        for (int k = 0; k < NR; k++) chk("t4_row", frame_data[k*FB +: FB], k < 4 ? nw[k] : wd[k]);
        // abort in IDLE does not block a header
        abort = 1; send(32'hA504_0A00, 0); abort = 0;
        chk("t4_idle_abort", busy, 1);
        for (int k = 0; k < NR; k++) send(wd[k], 0);
        wait_idle();
        chk("t4_done5", frames_done, 16'd5);

        // abort in STROBE keeps the strobe and skips HOLD
        frame(8'd5, 8'd5, 0);
        @(negedge clk);
        chk("t4_strobe_now", frame_strobe, onehot(105));
        abort = 1; @(negedge clk); abort = 0;
        chk("t4_strobe_abort_ready", bus.s_ready, 1);
        chk("t4_done6", frames_done, 16'd6);

        // reset in SETUP, then in STROBE
        frame(8'd6, 8'd6, 0);
        chk("t5_setup_busy", busy, 1);
        rst = 1; #1;
        chk("t5a_fs", frame_strobe, 0);
        chk("t5a_fd", frame_data, 0);
        chk("t5a_busy", busy, 0);
        chk("t5a_done", frames_done, 0);
        @(negedge clk); rst = 0; @(negedge clk);
        frame(8'd1, 8'd1, 0);
        @(negedge clk);
        chk("t5_strobe_on", |frame_strobe, 1);
        rst = 1; #1;
        chk("t5b_fs", frame_strobe, 0);
        chk("t5b_fd", frame_data, 0);
        chk("t5b_busy", busy, 0);
        chk("t5b_done", frames_done, 0);
        @(negedge clk); rst = 0; @(negedge clk);

        // frames_done wrap
        force dut.frames_done = 16'hFFFE;
        m_done = 16'hFFFE;
        @(negedge clk);
        release dut.frames_done;
        frame(8'd4, 8'd4, 0);
        wait_idle();
        chk("t6_ffff", frames_done, 16'hFFFF);
        frame(8'd4, 8'd5, 0);
        wait_idle();
        chk("t6_wrap", frames_done, 16'h0000);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [7:0] c, f, sy;
            int kind, w, ab;
            kind = $urandom_range(0, 7);
            c = 8'($urandom_range(0, NC - 1));
            f = 8'($urandom_range(0, MF - 1));
            sy = 8'hA5;
            if (kind == 0) c = 8'($urandom_range(NC, 255));
            if (kind == 1) f = 8'($urandom_range(MF, 255));
            if (kind == 2) sy = 8'($urandom_range(0, 255));
            err_clr = $urandom_range(0, 3) == 0;
            send({sy, c, f, 8'($urandom)}, $urandom_range(0, 2));
            err_clr = 0;
            if (sy == 8'hA5 && int'(c) < NC && int'(f) < MF) begin
                for (int k = 0; k < NR; k++) begin
                    if ($urandom_range(0, 19) == 0) begin
                        abort = 1; @(negedge clk); abort = 0;
                        break;
                    end
                    send($urandom, $urandom_range(0, 3));
                end
                w = $urandom_range(0, 4);
                ab = $urandom_range(0, 5);
                for (int j = 0; j < w; j++) begin
                    abort = j == ab;
                    err_clr = $urandom_range(0, 5) == 0;
                    @(negedge clk);
                    abort = 0; err_clr = 0;
                end
            end
        end
        wait_idle();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
